// File: rtl/rsa_pkg.sv
// Shared types and sizing helpers for the RSA operand loader and the accelerator it feeds.
package rsa_pkg;

  localparam int RSA_OPER_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_KEY,
    ST_LD_MOD,
    ST_LD_MSG,
    ST_START,
    ST_WAIT,
    ST_WB,
    ST_FIN
  } rsa_ld_state_e;

  function automatic int rsa_words(input int oper_w, input int data_w);
    return oper_w / data_w;
  endfunction

  // Byte span of one operand block in memory.
  function automatic int rsa_block_bytes(input int oper_w, input int data_w);
    return (oper_w / data_w) * (data_w / 8);
  endfunction

  function automatic int rsa_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rsa_mem_port.sv
// Single-outstanding req/resp sequencer: request strobe, word index and timeout counter.
module rsa_mem_port #(
  parameter int WORDS   = 2,
  parameter int IDX_W   = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic             i_clr,
  input  logic             i_resp,
  output logic             o_req,
  output logic             o_resp_ok,
  output logic             o_last,
  output logic             o_timeout,
  output logic [IDX_W-1:0] o_idx
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic             r_req;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  assign o_req     = r_req;
  assign o_idx     = r_idx;
  assign o_resp_ok = r_req && i_resp;
  assign o_last    = (r_idx == IDX_W'(WORDS - 1));
  assign o_timeout = (r_cnt >= CNT_W'(TIMEOUT - 1));

  // Request drops for one cycle after each response, and on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      r_req <= i_go && !o_resp_ok && !i_clr;
      if (i_clr)
        r_idx <= '0;
      else if (o_resp_ok)
        r_idx <= r_idx + 1'b1;
      if (i_clr || o_resp_ok)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(TIMEOUT))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rsa_operand_loader.sv
// Fetches key/modulus/message from memory, starts the RSA accelerator, writes the result back.
module rsa_operand_loader
  import rsa_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int OPER_W  = RSA_OPER_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [OPER_W-1:0] rsa_key,
  output logic [OPER_W-1:0] rsa_mod_n,
  output logic [OPER_W-1:0] rsa_msg_block,
  output logic              rsa_start,
  input  logic              rsa_complete,
  input  logic [OPER_W-1:0] rsa_result,
  output logic              done,
  output logic              error
);

  localparam int WORDS    = rsa_words(OPER_W, DATA_W);
  localparam int S_BYTES  = rsa_block_bytes(OPER_W, DATA_W);
  localparam int IDX_W    = rsa_idx_w(WORDS);
  localparam int WD_BYTES = DATA_W / 8;

  rsa_ld_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [OPER_W-1:0] r_key, r_mod, r_msg, r_res;
  logic              r_err;

  logic              w_go, w_clr, w_req, w_resp_ok, w_last, w_tmo;
  logic              w_accept, w_set_err, w_mod_zero;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_region;
  logic [OPER_W-1:0] w_mod_nxt;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_go      = (r_state == ST_LD_KEY) || (r_state == ST_LD_MOD) ||
                     (r_state == ST_LD_MSG) || (r_state == ST_WB);
  assign w_clr     = (w_state_nxt != r_state);

  rsa_mem_port #(
    .WORDS   (WORDS),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
  ) u_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_go      (w_go),
    .i_clr     (w_clr),
    .i_resp    (mem_resp),
    .o_req     (w_req),
    .o_resp_ok (w_resp_ok),
    .o_last    (w_last),
    .o_timeout (w_tmo),
    .o_idx     (w_idx)
  );

  // Modulus as it will look once the in-flight word lands; zero check happens on the last word.
  always_comb begin
    w_mod_nxt = r_mod;
    w_mod_nxt[int'(w_idx)*DATA_W +: DATA_W] = mem_rdata;
  end
  assign w_mod_zero = (w_mod_nxt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_LD_KEY;
      ST_LD_KEY: begin
        if (w_resp_ok && w_last)   w_state_nxt = ST_LD_MOD;
        else if (w_tmo)            begin w_state_nxt = ST_FIN; w_set_err = 1'b1; end
      end
      ST_LD_MOD: begin
        if (w_resp_ok && w_last) begin
          if (w_mod_zero)          begin w_state_nxt = ST_FIN; w_set_err = 1'b1; end
          else                     w_state_nxt = ST_LD_MSG;
        end else if (w_tmo)        begin w_state_nxt = ST_FIN; w_set_err = 1'b1; end
      end
      ST_LD_MSG: begin
        if (w_resp_ok && w_last)   w_state_nxt = ST_START;
        else if (w_tmo)            begin w_state_nxt = ST_FIN; w_set_err = 1'b1; end
      end
      ST_START:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rsa_complete)          w_state_nxt = ST_WB;
        else if (w_tmo)            begin w_state_nxt = ST_FIN; w_set_err = 1'b1; end
      end
      ST_WB: begin
        if (w_resp_ok && w_last)   w_state_nxt = ST_FIN;
        else if (w_tmo)            begin w_state_nxt = ST_FIN; w_set_err = 1'b1; end
      end
      ST_FIN:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_key   <= '0;
      r_mod   <= '0;
      r_msg   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_base <= cmd_base;
        r_key  <= '0;
        r_mod  <= '0;
        r_msg  <= '0;
        r_err  <= 1'b0;
      end
      if (w_set_err)
        r_err <= 1'b1;
      if (w_resp_ok) begin
        case (r_state)
          ST_LD_KEY: r_key[int'(w_idx)*DATA_W +: DATA_W] <= mem_rdata;
          ST_LD_MOD: r_mod <= w_mod_nxt;
          ST_LD_MSG: r_msg[int'(w_idx)*DATA_W +: DATA_W] <= mem_rdata;
          default:   ;
        endcase
      end
      if ((r_state == ST_WAIT) && rsa_complete)
        r_res <= rsa_result;
    end
  end

  always_comb begin
    case (r_state)
      ST_LD_MOD: w_region = 2'd1;
      ST_LD_MSG: w_region = 2'd2;
      ST_WB:     w_region = 2'd3;
      default:   w_region = 2'd0;
    endcase
  end

  assign mem_addr      = r_base + ADDR_W'(w_region) * ADDR_W'(S_BYTES)
                                + ADDR_W'(w_idx) * ADDR_W'(WD_BYTES);
  assign mem_wdata     = r_res[int'(w_idx)*DATA_W +: DATA_W];
  assign mem_read      = w_req && ((r_state == ST_LD_KEY) || (r_state == ST_LD_MOD) ||
                                   (r_state == ST_LD_MSG));
  assign mem_write     = w_req && (r_state == ST_WB);
  assign cmd_ready     = rst_n && (r_state == ST_IDLE);
  assign rsa_start     = (r_state == ST_START);
  assign done          = (r_state == ST_FIN);
  assign error         = r_err;
  assign rsa_key       = r_key;
  assign rsa_mod_n     = r_mod;
  assign rsa_msg_block = r_msg;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench: memory + accelerator models around rsa_operand_loader with hand-computed results.
module tb_rsa_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base = '0;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic [63:0] rsa_key, rsa_mod_n, rsa_msg_block;
  logic        rsa_start;
  logic        rsa_complete = 1'b0;
  logic [63:0] rsa_result = '0;
  logic        done, error;

  rsa_operand_loader #(
    .DATA_W(32), .ADDR_W(32), .OPER_W(64), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .rsa_key(rsa_key), .rsa_mod_n(rsa_mod_n), .rsa_msg_block(rsa_msg_block),
    .rsa_start(rsa_start), .rsa_complete(rsa_complete), .rsa_result(rsa_result),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:1023];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          n_resp = 0;
  int          resp_limit = 1000000;
  bit          acc_en = 1'b1;
  bit          acc_early = 1'b0;
  int          acc_cnt = 0;
  logic [63:0] acc_res = 64'hDEADBEEF_CAFEF00D;
  int          n_start = 0;
  int          n_acc = 0;
  bit          both_hi = 1'b0;

  // Zero-wait memory: grants in the cycle the request is seen; accelerator completes 10 cycles after start.
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_resp)
      mem_resp = 1'b0;
    else if ((mem_read || mem_write) && n_resp < resp_limit) begin
      mem_resp = 1'b1;
      n_resp++;
      if (mem_read) begin
        mem_rdata = mem[mem_addr[11:2]];
        rd_log.push_back(mem_addr);
      end else begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
    end
    if (rsa_complete) rsa_complete = 1'b0;
    if (!rst_n) acc_cnt = 0;
    else if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) begin
        rsa_complete = 1'b1;
        rsa_result   = acc_res;
      end
    end else if (rsa_start && acc_en) begin
      acc_cnt = 10;
      if (acc_early) begin
        rsa_complete = 1'b1;
        rsa_result   = 64'h11111111_22222222;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rsa_start) n_start++;
    if (cmd_valid && cmd_ready) n_acc++;
    if (mem_read && mem_write) both_hi = 1'b1;
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_addr.delete();
    wr_data.delete();
    n_start = 0;
  endtask

  task automatic send_cmd(input logic [31:0] base);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (cmd_ready) break;
    end
    if (k == 50) check("cmd_ready_wait", 64'd0, 64'd1);
    cmd_base  = base;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output logic err_o, output int cyc);
    err_o = 1'bx;
    for (cyc = 1; cyc <= maxc; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        err_o = error;
        return;
      end
    end
    check("done_wait", 64'd0, 64'd1);
  endtask

  task automatic wait_start(output int cyc);
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      if (rsa_start) return;
    end
    check("start_wait", 64'd0, 64'd1);
  endtask

  initial begin
    logic e;
    int   cyc;
    int   lat;
    int   dn;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[12'h100 >> 2] = 32'h00000001; mem[12'h104 >> 2] = 32'h00000002;
    mem[12'h108 >> 2] = 32'h11111111; mem[12'h10C >> 2] = 32'h22222222;
    mem[12'h110 >> 2] = 32'h33333333; mem[12'h114 >> 2] = 32'h44444444;
    mem[12'h200 >> 2] = 32'hA0A0A0A0; mem[12'h204 >> 2] = 32'hB0B0B0B0;
    mem[12'h208 >> 2] = 32'h00000000; mem[12'h20C >> 2] = 32'h80000000;
    mem[12'h210 >> 2] = 32'hC0C0C0C0; mem[12'h214 >> 2] = 32'hD0D0D0D0;
    mem[12'h300 >> 2] = 32'h00000009;
    mem[12'h400 >> 2] = 32'h00000005; mem[12'h408 >> 2] = 32'h00000007;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_start_done_err", {61'd0, rsa_start, done, error}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Job 1: base 0x100
    clear_logs();
    send_cmd(32'h100);
    wait_start(lat);
    check("start_latency", 64'(lat), 64'd12);
    wait_done(200, e, cyc);
    check("j1_error", 64'(e), 64'd0);
    check("j1_nreads", 64'(rd_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++)
      check($sformatf("j1_raddr%0d", i), 64'(rd_log[i]), 64'(32'h100 + 4 * i));
    check("j1_key", rsa_key, 64'h00000002_00000001);
    check("j1_mod", rsa_mod_n, 64'h22222222_11111111);
    check("j1_msg", rsa_msg_block, 64'h44444444_33333333);
    check("j1_nstart", 64'(n_start), 64'd1);
    check("j1_nwrites", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("j1_waddr0", 64'(wr_addr[0]), 64'h118);
      check("j1_wdata0", 64'(wr_data[0]), 64'hCAFEF00D);
      check("j1_waddr1", 64'(wr_addr[1]), 64'h11C);
      check("j1_wdata1", 64'(wr_data[1]), 64'hDEADBEEF);
    end
    @(posedge clk);
    #1;
    check("j1_done_pulse", 64'(done), 64'd0);
    check("j1_ready_back", 64'(cmd_ready), 64'd1);

    // Job 2: base 0x200, spurious complete alongside start must be ignored
    clear_logs();
    acc_early = 1'b1;
    acc_res   = 64'h01234567_89ABCDEF;
    send_cmd(32'h200);
    wait_done(200, e, cyc);
    acc_early = 1'b0;
    check("j2_error", 64'(e), 64'd0);
    check("j2_mod", rsa_mod_n, 64'h80000000_00000000);
    check("j2_nwrites", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("j2_waddr0", 64'(wr_addr[0]), 64'h218);
      check("j2_wdata0", 64'(wr_data[0]), 64'h89ABCDEF);
      check("j2_waddr1", 64'(wr_addr[1]), 64'h21C);
      check("j2_wdata1", 64'(wr_data[1]), 64'h01234567);
    end

    // Zero modulus
    clear_logs();
    send_cmd(32'h300);
    wait_done(200, e, cyc);
    check("mz_error", 64'(e), 64'd1);
    check("mz_nreads", 64'(rd_log.size()), 64'd4);
    check("mz_nstart", 64'(n_start), 64'd0);
    check("mz_nwrites", 64'(wr_addr.size()), 64'd0);

    // Timeout in LD_MSG
    clear_logs();
    resp_limit = n_resp + 4;
    send_cmd(32'h400);
    wait_done(1300, e, cyc);
    check("tmo_error", 64'(e), 64'd1);
    check("tmo_read_dropped", 64'(mem_read), 64'd0);
    check("tmo_not_early", 64'(cyc >= 1024), 64'd1);
    check("tmo_nreads", 64'(rd_log.size()), 64'd4);
    check("tmo_nstart", 64'(n_start), 64'd0);
    resp_limit = 1000000;
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 64'(error), 64'd1);

    // Reset during WAIT
    clear_logs();
    acc_en  = 1'b0;
    acc_res = 64'hDEADBEEF_CAFEF00D;
    send_cmd(32'h100);
    check("err_cleared_on_accept", 64'(error), 64'd0);
    wait_start(lat);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("wrst_rw", {62'd0, mem_read, mem_write}, 64'd0);
    check("wrst_addr", 64'(mem_addr), 64'd0);
    check("wrst_wdata", 64'(mem_wdata), 64'd0);
    check("wrst_key", rsa_key, 64'd0);
    check("wrst_mod", rsa_mod_n, 64'd0);
    check("wrst_msg", rsa_msg_block, 64'd0);
    check("wrst_ctl", {60'd0, rsa_start, done, error, cmd_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    acc_en = 1'b1;
    #1;
    check("wrst_ready", 64'(cmd_ready), 64'd1);
    check("wrst_nwrites", 64'(wr_addr.size()), 64'd0);
    clear_logs();
    send_cmd(32'h100);
    wait_done(200, e, cyc);
    check("post_rst_error", 64'(e), 64'd0);
    check("post_rst_nwrites", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2)
      check("post_rst_wdata1", 64'(wr_data[1]), 64'hDEADBEEF);

    // cmd_valid held high across two jobs
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    n_acc     = 0;
    cmd_base  = 32'h200;
    cmd_valid = 1'b1;
    dn = 0;
    for (int k = 0; k < 300 && dn < 2; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        if (dn == 2) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_ndone", 64'(dn), 64'd2);
    check("hold_naccept", 64'(n_acc), 64'd2);
    check("hold_nstart", 64'(n_start), 64'd2);
    check("hold_nwrites", 64'(wr_addr.size()), 64'd4);
    check("rw_exclusive", 64'(both_hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
